// File: rtl/serial_to_parallel_lane_pkg.sv
// Shared lane definitions for the serial link (receive and transmit sides).
// Holds the lane width, the default idle/comma word, the alignment state
// encoding and a helper that sizes the idle-word counter from LOCK_COUNT.
package serial_to_parallel_lane_pkg;

  localparam int unsigned LANE_WIDTH    = 32;
  localparam int unsigned BIT_CNT_WIDTH = $clog2(LANE_WIDTH);

  localparam logic [LANE_WIDTH-1:0] IDLE_WORD_DEFAULT = 32'hBCBCBCBC;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StAlign  = 2'd1,
    StLocked = 2'd2
  } lane_state_e;

  // Idle counter must hold LOCK_COUNT; kept within 2..3 bits (LOCK_COUNT 1..7).
  function automatic int unsigned idle_cnt_width(input int unsigned lock_count);
    int unsigned w;
    w = $clog2(lock_count + 1);
    if (w < 2) w = 2;
    if (w > 3) w = 3;
    return w;
  endfunction

endpackage

// File: rtl/serial_to_parallel_lane_idle_detector.sv
// Serial shift register plus idle-word comparator.
// Ports:
//   clk_i       - bit clock, one serial bit per rising edge
//   rst_i       - asynchronous active-high reset, clears the shift register
//   data_i      - serial bit, words arrive MSB first
//   next_word_o - shift register contents including the bit on data_i
//   match_o     - next_word_o equals IDLE_WORD
module serial_to_parallel_lane_idle_detector
  import serial_to_parallel_lane_pkg::*;
#(
  parameter logic [LANE_WIDTH-1:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_i,
  output logic [LANE_WIDTH-1:0] next_word_o,
  output logic                  match_o
);

  logic [LANE_WIDTH-1:0] shift_q, shift_d;

  // The word is visible combinationally on the edge that samples its last bit,
  // so the FSM can act on it with no added latency.
  always_comb begin
    next_word_o = {shift_q[LANE_WIDTH-2:0], data_i};
    match_o     = (next_word_o == IDLE_WORD);
    shift_d     = next_word_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/serial_to_parallel_lane.sv
// Serial-to-parallel receive lane with idle-word word alignment.
// Searches the bit stream for IDLE_WORD, confirms LOCK_COUNT consecutive idles
// on 32-bit boundaries, then delivers each non-idle word on lane.
// Ports:
//   clk_32f     - bit clock, one serial bit per rising edge
//   reset       - asynchronous active-high reset
//   data_in     - serial lane bit, MSB first
//   lane        - recovered 32-bit data word (0 for idle)
//   valid       - lane holds a non-idle data word
//   word_strobe - one-cycle pulse on every word boundary while locked
//   active      - lane is locked
module serial_to_parallel_lane
  import serial_to_parallel_lane_pkg::*;
#(
  parameter logic [LANE_WIDTH-1:0] IDLE_WORD  = IDLE_WORD_DEFAULT,
  parameter int unsigned           LOCK_COUNT = 4
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  input  logic                  data_in,
  output logic [LANE_WIDTH-1:0] lane,
  output logic                  valid,
  output logic                  word_strobe,
  output logic                  active
);

  localparam int unsigned IdleCntW = idle_cnt_width(LOCK_COUNT);

  localparam logic [IdleCntW-1:0]      IdleCntMax = IdleCntW'(LOCK_COUNT);
  localparam logic [IdleCntW-1:0]      IdleCntOne = {{(IdleCntW-1){1'b0}}, 1'b1};
  localparam logic [BIT_CNT_WIDTH-1:0] BitCntOne  = {{(BIT_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BIT_CNT_WIDTH-1:0] BitCntLast = '1;

  lane_state_e               state_q, state_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IdleCntW-1:0]       idle_cnt_q, idle_cnt_d;
  logic [LANE_WIDTH-1:0]     lane_q, lane_d;
  logic                      valid_q, valid_d;
  logic                      strobe_q, strobe_d;

  logic [LANE_WIDTH-1:0]     next_word;
  logic                      idle_match;
  logic                      boundary;
  logic [IdleCntW-1:0]       idle_cnt_inc;

  serial_to_parallel_lane_idle_detector #(
    .IDLE_WORD (IDLE_WORD)
  ) u_idle_detector (
    .clk_i       (clk_32f),
    .rst_i       (reset),
    .data_i      (data_in),
    .next_word_o (next_word),
    .match_o     (idle_match)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    lane_d       = lane_q;
    valid_d      = valid_q;
    strobe_d     = 1'b0;
    // Boundary edge: the 32nd edge after the anchoring idle match.
    boundary     = (bit_cnt_q == BitCntLast);
    idle_cnt_inc = idle_cnt_q + IdleCntOne;

    unique case (state_q)
      StSearch: begin
        bit_cnt_d  = '0;
        idle_cnt_d = '0;
        if (idle_match) begin
          idle_cnt_d = IdleCntOne;
          state_d    = (LOCK_COUNT <= 1) ? StLocked : StAlign;
        end
      end

      StAlign: begin
        bit_cnt_d = bit_cnt_q + BitCntOne;
        if (boundary) begin
          if (idle_match) begin
            if (idle_cnt_q < IdleCntMax) idle_cnt_d = idle_cnt_inc;
            if (idle_cnt_inc >= IdleCntMax) state_d = StLocked;
          end else begin
            // Misaligned or data before lock: restart the search from scratch.
            state_d    = StSearch;
            idle_cnt_d = '0;
            bit_cnt_d  = '0;
          end
        end
      end

      StLocked: begin
        bit_cnt_d = bit_cnt_q + BitCntOne;
        if (boundary) begin
          strobe_d = 1'b1;
          if (idle_match) begin
            lane_d  = '0;
            valid_d = 1'b0;
          end else begin
            lane_d  = next_word;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StSearch;
      end
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q    <= StSearch;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      lane_q     <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      lane_q     <= lane_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
    end
  end

  // LOCKED is left only through reset, so active is simply the locked state.
  assign active      = (state_q == StLocked);
  assign lane        = lane_q;
  assign valid       = valid_q;
  assign word_strobe = strobe_q;

endmodule

// File: tb/tb_serial_to_parallel_lane.sv
// Self-checking bench for serial_to_parallel_lane: directed scenarios plus
// randomized word streams, compared every edge against a bit-history model.
module tb_serial_to_parallel_lane;

  localparam logic [31:0] Idle      = 32'hBCBCBCBC;
  localparam int          LockCount = 4;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic        data_in;
  logic [31:0] lane;
  logic        valid;
  logic        word_strobe;
  logic        active;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit          hist[$];
  int          m_phase;  // 0 searching, 1 confirming, 2 locked
  int          m_idles;
  longint      m_edge;
  longint      m_anchor;
  logic [31:0] m_lane;
  logic        m_valid;
  logic        m_strobe;
  logic        m_active;

  serial_to_parallel_lane dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .lane        (lane),
    .valid       (valid),
    .word_strobe (word_strobe),
    .active      (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (32) hist.push_back(1'b0);
    m_phase  = 0;
    m_idles  = 0;
    m_edge   = 0;
    m_anchor = 0;
    m_lane   = '0;
    m_valid  = 1'b0;
    m_strobe = 1'b0;
    m_active = 1'b0;
  endtask

  // Last 32 received bits; word boundaries are every 32 edges after the
  // edge where the first idle word was seen.
  task automatic model_step(input bit b);
    logic [31:0] w;
    bit          bnd;
    hist.push_back(b);
    if (hist.size() > 32) void'(hist.pop_front());
    w = '0;
    foreach (hist[i]) w = {w[30:0], hist[i]};
    m_edge++;
    m_strobe = 1'b0;
    bnd = (m_edge > m_anchor) && (((m_edge - m_anchor) % 32) == 0);
    case (m_phase)
      0: if (w == Idle) begin
        m_anchor = m_edge;
        m_idles  = 1;
        m_phase  = 1;
      end
      1: if (bnd) begin
        if (w == Idle) begin
          m_idles++;
          if (m_idles >= LockCount) m_phase = 2;
        end else begin
          m_phase = 0;
          m_idles = 0;
        end
      end
      default: if (bnd) begin
        m_strobe = 1'b1;
        if (w == Idle) begin
          m_lane  = '0;
          m_valid = 1'b0;
        end else begin
          m_lane  = w;
          m_valid = 1'b1;
        end
      end
    endcase
    m_active = (m_phase == 2);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_lane"}, lane, m_lane);
    check_eq({tag, "_valid"}, 32'(valid), 32'(m_valid));
    check_eq({tag, "_strobe"}, 32'(word_strobe), 32'(m_strobe));
    check_eq({tag, "_active"}, 32'(active), 32'(m_active));
  endtask

  task automatic tick(input bit b);
    data_in = b;
    @(posedge clk_32f);
    if (reset) model_reset();
    else model_step(b);
    #1;
    compare_all("edge");
  endtask

  task automatic send_range(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) tick(w[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_range(w, 31, 0);
  endtask

  // Assert reset between clock edges and check clearing before any edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all("async_rst");
    check_eq("async_rst_active_zero", 32'(active), 32'd0);
    check_eq("async_rst_lane_zero", lane, 32'd0);
    tick(1'b1);
    tick(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    model_reset();
    #2;
    compare_all("rst0");

    // Reset held for 5 edges with data toggling.
    for (int i = 0; i < 5; i++) tick(1'(i & 1));
    reset = 1'b0;

    // Zeros then four idles: lock exactly on the last bit of the 4th idle.
    send_range(32'h0, 9, 0);
    repeat (3) send_word(Idle);
    send_range(Idle, 31, 1);
    check_eq("pre_lock_active", 32'(active), 32'd0);
    check_eq("pre_lock_valid", 32'(valid), 32'd0);
    check_eq("pre_lock_strobe", 32'(word_strobe), 32'd0);
    send_range(Idle, 0, 0);
    check_eq("lock_active", 32'(active), 32'd1);

    // Data words then idle after lock.
    send_word(32'hFFFFFFFF);
    check_eq("ff_lane", lane, 32'hFFFFFFFF);
    check_eq("ff_valid", 32'(valid), 32'd1);
    check_eq("ff_strobe", 32'(word_strobe), 32'd1);
    tick(1'b1);
    check_eq("ff_strobe_drop", 32'(word_strobe), 32'd0);
    send_range(32'hEEEEEEEE, 30, 0);
    check_eq("ee_lane", lane, 32'hEEEEEEEE);
    check_eq("ee_strobe", 32'(word_strobe), 32'd1);
    send_word(Idle);
    check_eq("idle_lane", lane, 32'd0);
    check_eq("idle_valid", 32'(valid), 32'd0);

    // Reset mid-word while locked with a data word on the lane.
    send_word(32'h12345678);
    check_eq("pre_rst_lane", lane, 32'h12345678);
    send_range(32'hA5A5A5A5, 31, 22);
    async_reset();
    repeat (3) send_word(Idle);
    check_eq("relock_wait", 32'(active), 32'd0);
    send_word(Idle);
    check_eq("relock", 32'(active), 32'd1);

    // Five garbage bits, then idles: word must come out unshifted.
    async_reset();
    send_range(32'h16, 4, 0);
    repeat (4) send_word(Idle);
    check_eq("garbage_lock", 32'(active), 32'd1);
    send_word(32'h00000003);
    check_eq("garbage_lane", lane, 32'h00000003);
    check_eq("garbage_valid", 32'(valid), 32'd1);

    // Data word during alignment sends the lane back to search.
    async_reset();
    repeat (2) send_word(Idle);
    send_word(32'h00000004);
    check_eq("abort_active", 32'(active), 32'd0);
    repeat (3) send_word(Idle);
    check_eq("abort_wait", 32'(active), 32'd0);
    send_word(Idle);
    check_eq("abort_relock", 32'(active), 32'd1);

    // Randomized streams: random garbage prefix, idles, mixed data/idle words.
    for (int run = 0; run < 4; run++) begin
      int nbits;
      async_reset();
      nbits = int'($urandom_range(40, 0));
      for (int i = 0; i < nbits; i++) tick(1'($urandom & 1));
      repeat (LockCount + int'($urandom_range(2, 0))) send_word(Idle);
      for (int k = 0; k < 20; k++) begin
        if ($urandom_range(3, 0) == 0) send_word(Idle);
        else send_word($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
